// File: rtl/wb_pwm_fader.sv
// Wishbone fader: steps wb_pwm duties one LSB per tick toward targets; slave acks 1 cycle after stb, never stalls.
// Master holds stb/addr/data through i_pwm_stall; optional o_irq + status reg under WB_PWM_FADER_IRQ_EN.
module wb_pwm_fader #(
  parameter int WB_ADDR_BITS = 32,
  parameter int PWM_BITS     = 4,
  parameter int PWM_PINS     = 1,
  parameter int DIV_BITS     = 16,
  parameter int DEFAULT_DIV  = 1000
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  input  logic                    i_wb_stb,
  input  logic                    i_wb_we,
  input  logic [WB_ADDR_BITS-1:0] i_wb_addr,
  input  logic [31:0]             i_wb_data,
  output logic [31:0]             o_wb_data,
  output logic                    o_wb_stall,
  output logic                    o_wb_ack,
  output logic                    o_pwm_stb,
  output logic                    o_pwm_we,
  output logic [WB_ADDR_BITS-1:0] o_pwm_addr,
  output logic [31:0]             o_pwm_data,
  input  logic                    i_pwm_stall,
  input  logic                    i_pwm_ack
`ifdef WB_PWM_FADER_IRQ_EN
  , output logic                  o_irq
`endif
);

  localparam int CH_W = (PWM_PINS > 1) ? $clog2(PWM_PINS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [PWM_BITS-1:0] nxt_q, nxt_d;
  logic                pend_q, pend_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [PWM_BITS-1:0] cur_q [PWM_PINS];
  logic [PWM_BITS-1:0] cur_d [PWM_PINS];
  logic [PWM_BITS-1:0] tgt_q [PWM_PINS];
  logic [PWM_BITS-1:0] tgt_d [PWM_PINS];
  logic                ack_q, ack_d;
  logic [31:0]         rdat_q, rdat_d;

  logic                wr, is_ch, is_div, tick, advance;
  logic [CH_W-1:0]     idx;
  logic                unused_data;

`ifdef WB_PWM_FADER_IRQ_EN
  logic irq_q, irq_d;
  logic wrote_q, wrote_d;
  logic settled, settled_next;
`endif

  assign unused_data = &{1'b0, i_wb_data};

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    nxt_d   = nxt_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    ack_d   = i_wb_stb;
    rdat_d  = '0;
    tick    = 1'b0;
    advance = 1'b0;
    wr      = i_wb_stb & i_wb_we;
    is_ch   = i_wb_addr < WB_ADDR_BITS'(PWM_PINS);
    is_div  = i_wb_addr == WB_ADDR_BITS'(PWM_PINS);
    idx     = i_wb_addr[CH_W-1:0];
`ifdef WB_PWM_FADER_IRQ_EN
    irq_d        = 1'b0;
    wrote_d      = wrote_q;
    settled      = 1'b1;
    settled_next = 1'b1;
    for (int n = 0; n < PWM_PINS; n++) begin
      if (cur_q[n] != tgt_q[n]) settled = 1'b0;
    end
`endif

    if (i_wb_stb && !i_wb_we) begin
      if (is_ch)       rdat_d = 32'(cur_q[idx]);
      else if (is_div) rdat_d = 32'(div_q);
`ifdef WB_PWM_FADER_IRQ_EN
      else if (i_wb_addr == WB_ADDR_BITS'(PWM_PINS + 1)) rdat_d = {31'd0, settled};
`endif
    end
    if (wr && is_ch) tgt_d[idx] = i_wb_data[PWM_BITS-1:0];

    // A div write restarts the period and suppresses any tick that cycle.
    if (wr && is_div) begin
      div_d = i_wb_data[DIV_BITS-1:0];
      cnt_d = '0;
    end else if (div_q == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= div_q - DIV_BITS'(1)) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          ch_d    = '0;
          state_d = SCAN;
`ifdef WB_PWM_FADER_IRQ_EN
          wrote_d = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (cur_q[ch_q] != tgt_q[ch_q]) begin
          nxt_d   = (tgt_q[ch_q] > cur_q[ch_q]) ? cur_q[ch_q] + PWM_BITS'(1)
                                                : cur_q[ch_q] - PWM_BITS'(1);
          state_d = REQ;
        end else begin
          advance = 1'b1;
        end
      end
      REQ: begin
        if (!i_pwm_stall) begin
`ifdef WB_PWM_FADER_IRQ_EN
          wrote_d = 1'b1;
`endif
          if (i_pwm_ack) begin
            cur_d[ch_q] = nxt_q;
            advance     = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_pwm_ack) begin
          cur_d[ch_q] = nxt_q;
          advance     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (ch_q == CH_W'(PWM_PINS - 1)) begin
        state_d = IDLE;
      end else begin
        ch_d    = ch_q + CH_W'(1);
        state_d = SCAN;
      end
    end

    if (tick) pend_d = 1'b1;

`ifdef WB_PWM_FADER_IRQ_EN
    for (int n = 0; n < PWM_PINS; n++) begin
      if (cur_d[n] != tgt_q[n]) settled_next = 1'b0;
    end
    irq_d = advance && (state_d == IDLE) && wrote_d && settled_next;
`endif
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      nxt_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= DIV_BITS'(DEFAULT_DIV);
      cur_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      ack_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef WB_PWM_FADER_IRQ_EN
      irq_q   <= 1'b0;
      wrote_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      nxt_q   <= nxt_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
`ifdef WB_PWM_FADER_IRQ_EN
      irq_q   <= irq_d;
      wrote_q <= wrote_d;
`endif
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdat_q;
  assign o_wb_stall = 1'b0;
  assign o_pwm_stb  = (state_q == REQ);
  assign o_pwm_we   = 1'b1;
  assign o_pwm_addr = WB_ADDR_BITS'(ch_q);
  assign o_pwm_data = 32'(nxt_q);
`ifdef WB_PWM_FADER_IRQ_EN
  assign o_irq      = irq_q;
`endif

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Directed bench for wb_pwm_fader with two 4-bit channels and a small acking PWM slave model.
module tb_wb_pwm_fader;

  logic        clk;
  logic        rst;
  logic        wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdat;
  logic [31:0] wb_rdat;
  logic        wb_stall, wb_ack;
  logic        pwm_stb, pwm_we;
  logic [31:0] pwm_addr, pwm_data;
  logic        pwm_stall, pwm_ack;

  logic        ack_q, ack_en, ack_force;
  int          n_tests, n_fail;
  int          cyc, stb_cnt, viol;
  logic        hold_q;
  logic [31:0] haddr, hdata;
  logic [31:0] rd;
  int          base;

  typedef struct { int a; int d; int c; } wr_t;
  wr_t wq[$];

  wb_pwm_fader #(.PWM_PINS(2), .PWM_BITS(4)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_wb_stb   (wb_stb),
    .i_wb_we    (wb_we),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_wdat),
    .o_wb_data  (wb_rdat),
    .o_wb_stall (wb_stall),
    .o_wb_ack   (wb_ack),
    .o_pwm_stb  (pwm_stb),
    .o_pwm_we   (pwm_we),
    .o_pwm_addr (pwm_addr),
    .o_pwm_data (pwm_data),
    .i_pwm_stall(pwm_stall),
    .i_pwm_ack  (pwm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pwm_ack = ack_q | ack_force;

  // PWM slave model: acks one cycle after acceptance; records accepted writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && pwm_stb === 1'b1) begin
      stb_cnt <= stb_cnt + 1;
      if (!pwm_stall) wq.push_back('{int'(pwm_addr), int'(pwm_data), cyc});
    end
    if (hold_q && !(pwm_stb === 1'b1 && pwm_addr == haddr && pwm_data == hdata))
      viol <= viol + 1;
    hold_q <= !rst && pwm_stb === 1'b1 && pwm_stall;
    haddr  <= pwm_addr;
    hdata  <= pwm_data;
    ack_q  <= ack_en && !rst && pwm_stb === 1'b1 && !pwm_stall;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    wb_stb = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdat = d;
    step();
    wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    wb_stb = 1'b1; wb_we = 1'b0; wb_addr = a;
    step();
    chk("rd_ack", {31'd0, wb_ack}, 32'd1);
    d = wb_rdat;
    wb_stb = 1'b0;
    step();
    chk("rd_idle_data", wb_rdat, 32'd0);
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wq.size() < n; i++) step();
    chk(tag, (wq.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; stb_cnt = 0; viol = 0; hold_q = 1'b0;
    haddr = '0; hdata = '0; ack_q = 1'b0; ack_en = 1'b1; ack_force = 1'b0;
    rst = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdat = '0; pwm_stall = 1'b0;
    step(3);
    rst = 1'b0;

    // 1: reset state and register defaults
    chk("t1_ack_rst", {31'd0, wb_ack}, 32'd0);
    chk("t1_data_rst", wb_rdat, 32'd0);
    chk("t1_stb_rst", {31'd0, pwm_stb}, 32'd0);
    chk("t1_we_const", {31'd0, pwm_we}, 32'd1);
    chk("t1_stall_const", {31'd0, wb_stall}, 32'd0);
    wb_read(0, rd); chk("t1_cur0", rd, 32'd0);
    wb_read(1, rd); chk("t1_cur1", rd, 32'd0);
    wb_read(2, rd); chk("t1_div", rd, 32'd1000);
    wb_read(7, rd); chk("t1_unmapped", rd, 32'd0);
    step(20);
    chk("t1_no_stb", stb_cnt, 32'd0);

    // 2: single-channel ramp 0 -> 3
    base = wq.size();
    wb_write(2, 4);
    wb_write(0, 3);
    wait_q("t2_timeout", base + 3, 200);
    step(30);
    chk("t2_count", wq.size() - base, 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t2_addr", wq[base+k].a, 32'd0);
      chk("t2_data", wq[base+k].d, k + 1);
    end
    chk("t2_gap01", (wq[base+1].c - wq[base].c >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk("t2_gap12", (wq[base+2].c - wq[base+1].c >= 4) ? 32'd1 : 32'd0, 32'd1);
    wb_read(0, rd); chk("t2_cur0", rd, 32'd3);

    // 3: two channels, down and up, interleaved per tick
    base = wq.size();
    wb_write(2, 0);
    wb_write(0, 0);
    wb_write(1, 2);
    wb_write(2, 4);
    wait_q("t3_timeout", base + 5, 300);
    step(30);
    chk("t3_count", wq.size() - base, 32'd5);
    if (wq.size() - base >= 5) begin
      chk("t3_w0", {wq[base].a[15:0], wq[base].d[15:0]}, {16'd0, 16'd2});
      chk("t3_w1", {wq[base+1].a[15:0], wq[base+1].d[15:0]}, {16'd1, 16'd1});
      chk("t3_w2", {wq[base+2].a[15:0], wq[base+2].d[15:0]}, {16'd0, 16'd1});
      chk("t3_w3", {wq[base+3].a[15:0], wq[base+3].d[15:0]}, {16'd1, 16'd2});
      chk("t3_w4", {wq[base+4].a[15:0], wq[base+4].d[15:0]}, {16'd0, 16'd0});
    end
    wb_read(0, rd); chk("t3_cur0", rd, 32'd0);
    wb_read(1, rd); chk("t3_cur1", rd, 32'd2);

    // 4: stall holds the request stable; excess ticks collapse
    base = wq.size();
    wb_write(2, 0);
    pwm_stall = 1'b1;
    wb_write(0, 1);
    wb_write(2, 4);
    for (int i = 0; i < 50 && pwm_stb !== 1'b1; i++) step();
    chk("t4_stb_seen", {31'd0, pwm_stb}, 32'd1);
    step(10);
    chk("t4_stb_held", {31'd0, pwm_stb}, 32'd1);
    chk("t4_addr_held", pwm_addr, 32'd0);
    chk("t4_data_held", pwm_data, 32'd1);
    pwm_stall = 1'b0;
    step(40);
    chk("t4_count", wq.size() - base, 32'd1);
    if (wq.size() > base) chk("t4_data", wq[base].d, 32'd1);
    chk("t4_stable", viol, 32'd0);
    wb_read(0, rd); chk("t4_cur0", rd, 32'd1);

    // 5: div = 0 pauses stepping; re-enable resumes
    base = wq.size();
    wb_write(2, 0);
    wb_write(0, 5);
    step(100);
    chk("t5_paused", wq.size() - base, 32'd0);
    chk("t5_cnt_held", dut.cnt_q, 32'd0);
    wb_write(2, 2);
    wait_q("t5_timeout", base + 4, 200);
    step(20);
    chk("t5_count", wq.size() - base, 32'd4);
    if (wq.size() - base >= 4) chk("t5_last", wq[base+3].d, 32'd5);
    wb_read(0, rd); chk("t5_cur0", rd, 32'd5);

    // 6: reset while waiting for ack; late ack must be ignored
    base = wq.size();
    ack_en = 1'b0;
    wb_write(0, 2);
    wait_q("t6_timeout", base + 1, 100);
    step(3);
    chk("t6_wait_stb", {31'd0, pwm_stb}, 32'd0);
    rst = 1'b1;
    step();
    chk("t6_rst_stb", {31'd0, pwm_stb}, 32'd0);
    rst = 1'b0;
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    ack_en = 1'b1;
    wb_read(0, rd); chk("t6_cur0", rd, 32'd0);
    wb_read(1, rd); chk("t6_cur1", rd, 32'd0);
    wb_read(2, rd); chk("t6_div", rd, 32'd1000);
    base = wq.size();
    wb_write(2, 2);
    step(50);
    chk("t6_tgt_cleared", wq.size() - base, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_pwm_fader.md
Name: wb_pwm_fader

Overview:
Sequencer that ramps the duty cycles of a wb_pwm instance towards software-set targets, one step per programmable tick.
- Wishbone B4 slave on the CPU side: targets and step period are written here; current duties are read back here.
- Wishbone master on the PWM side: issues duty-cycle writes to the PWM slave at addresses 0..PWM_PINS-1.
- Placed between the interconnect and wb_pwm, it gives smooth fades without CPU involvement.

Parameters:
- WB_ADDR_BITS, 32, address width of both Wishbone ports.
- PWM_BITS, 4, duty-cycle width per channel.
- PWM_PINS, 1, number of channels, 1..16.
- DIV_BITS, 16, width of the step-period register and tick counter.
- DEFAULT_DIV, 1000, step period after reset, in clocks.

Ports:
- i_wb_clk  in  1  clock for all logic.
- i_wb_rst  in  1  reset, synchronous, active-high.
- i_wb_stb  in  1  slave strobe.
- i_wb_we  in  1  slave write enable.
- i_wb_addr  in  WB_ADDR_BITS  slave address.
- i_wb_data  in  32  slave write data.
- o_wb_data  out  32  slave read data.
- o_wb_stall  out  1  slave stall; always 0.
- o_wb_ack  out  1  slave ack.
- o_pwm_stb  out  1  master strobe to wb_pwm.
- o_pwm_we  out  1  master write enable; always 1.
- o_pwm_addr  out  WB_ADDR_BITS  master address = channel index.
- o_pwm_data  out  32  master write data = duty, zero-extended.
- i_pwm_stall  in  1  stall from wb_pwm.
- i_pwm_ack  in  1  ack from wb_pwm.

Behaviour:
- Reset (synchronous, active-high; the only reset):
  - All targets = 0, all current duties = 0, div = DEFAULT_DIV, tick counter = 0, pending = 0, FSM = IDLE.
  - o_wb_ack = 0, o_wb_data = 0, o_pwm_stb = 0.
  - Asserting reset while a master cycle is outstanding drops o_pwm_stb at the next edge; the unfinished write is abandoned and current duties are not updated.
- Slave register map:
  - Addr n < PWM_PINS: write sets target[n] = i_wb_data[PWM_BITS-1:0]; read returns current[n], zero-extended.
  - Addr PWM_PINS: read/write div, low DIV_BITS bits.
  - Other addresses: writes are ignored; reads return 0.
- Slave timing:
  - Every strobe is acked exactly 1 cycle later.
  - o_wb_data is valid in the ack cycle and holds 0 otherwise.
  - No stall.
- Tick generation:
  - The counter runs 0..div-1; the tick fires on the cycle it wraps to 0.
  - div = 0 pauses the counter: no ticks, counter held at 0.
  - Writing div resets the counter to 0.
- Pending flag:
  - A tick sets pending.
  - Further ticks while pending is set are dropped (no queueing).
- FSM states: IDLE, SCAN, REQ, WAIT.
  - IDLE: if pending, clear pending, ch = 0, go to SCAN.
  - SCAN: if current[ch] != target[ch]:
    - next = current +1 if target > current, else current -1;
    - go to REQ.
  - SCAN, otherwise:
    - if ch = PWM_PINS-1, go to IDLE;
    - else ch+1 and stay in SCAN.
  - REQ: o_pwm_stb = 1, addr = ch, data = next.
    - Held stable until a cycle with !i_pwm_stall, then go to WAIT.
  - WAIT: o_pwm_stb = 0.
    - On i_pwm_ack: current[ch] = next, then advance ch as in SCAN.
    - An ack in the same cycle stb is accepted is also valid; the FSM then moves to SCAN or IDLE directly.
- Step size:
  - At most one LSB per channel per tick.
  - Unsigned arithmetic: no wrap-around below 0 or above 2^PWM_BITS-1.
  - Equal values produce no bus cycle.
- Target write mid-ramp: takes effect at the next SCAN of that channel; an in-flight write completes unchanged.
- Target write during WAIT for the same channel: current is still updated to next; the ramp then continues towards the new target.

Optional Feature:
WB_PWM_FADER_IRQ_EN
- Defined:
  - Adds output o_irq (1 bit, reset 0).
  - o_irq pulses high for one cycle when a pass returns to IDLE with every current[n] equal to target[n], and at least one write was issued in that pass.
  - Adds a read-only status register at addr PWM_PINS+1: bit0 = all channels settled.
- Undefined: no o_irq port; addr PWM_PINS+1 reads 0.

Test Plan:
All scenarios use PWM_PINS=2, PWM_BITS=4.
1. Reset, then read addr 0, 1, 2 -> reads 0, 0, DEFAULT_DIV; o_pwm_stb never asserts.
2. div=4, target[0]=3 -> writes to addr 0 with data 1, 2, 3, at least 4 clocks apart; then bus idle; reading addr 0 returns 3.
3. div=4, current[0]=3, target[0]=0, target[1]=2 -> per tick, writes to addr 0 and then addr 1 in that order; final current = {0, 2}.
4. Hold i_pwm_stall=1 for 10 cycles during REQ -> stb, addr and data are stable throughout; exactly one write is accepted; excess ticks are dropped with no duplicate write.
5. div=0 with target != current -> no master cycles for 100 clocks; then writing div=2 resumes stepping.
6. Assert i_wb_rst during WAIT -> o_pwm_stb=0 after the edge; current and target reset to 0; the late i_pwm_ack is ignored.
